deemph_stereo_sched: RTL and testbench

//  Shares one channel-interleaved de-emphasis datapath between the left and right audio streams.

---
 rtl/deemph_stereo_sched.sv | 119 +++++++++++
 tb/tb_deemph_stereo_sched.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/deemph_stereo_sched.sv
// Stereo scheduler for a shared de-emphasis datapath: issues L,R,L,R into the
// datapath, steers results back alternately, and caps in-flight samples with a credit count.
module deemph_stereo_sched #(
    parameter int DATA_WIDTH   = 32,
    parameter int MAX_INFLIGHT = 64,
    parameter int CW           = $clog2(MAX_INFLIGHT + 1)  // derived; leave at default
) (
    input  logic                  clock_i,
    input  logic                  reset_ni,
    input  logic                  enable_i,
    input  logic                  l_empty_i,
    output logic                  l_rd_en_o,
    input  logic [DATA_WIDTH-1:0] l_dout_i,
    input  logic                  r_empty_i,
    output logic                  r_rd_en_o,
    input  logic [DATA_WIDTH-1:0] r_dout_i,
    input  logic                  dp_full_i,
    output logic                  dp_wr_en_o,
    output logic [DATA_WIDTH-1:0] dp_din_o,
    input  logic                  dp_empty_i,
    output logic                  dp_rd_en_o,
    input  logic [DATA_WIDTH-1:0] dp_dout_i,
    input  logic                  lo_full_i,
    output logic                  lo_wr_en_o,
    output logic [DATA_WIDTH-1:0] lo_din_o,
    input  logic                  ro_full_i,
    output logic                  ro_wr_en_o,
    output logic [DATA_WIDTH-1:0] ro_din_o,
    output logic [CW-1:0]         in_flight_o,
    output logic [31:0]           pair_cnt_o,
    output logic                  busy_o
);

    typedef enum logic {ISS_L = 1'b0, ISS_R = 1'b1} iss_t;
    typedef enum logic {RET_L = 1'b0, RET_R = 1'b1} ret_t;

    iss_t          iss_q, iss_d;
    ret_t          ret_q, ret_d;
    logic [CW-1:0] in_flight_q, in_flight_d;
    logic [31:0]   pair_cnt_q, pair_cnt_d;
    logic          credit_ok;
    logic          issue;
    logic          ret;
    logic          pair_done;

    assign credit_ok = (in_flight_q < CW'(MAX_INFLIGHT));

    always_comb begin
        iss_d      = iss_q;
        ret_d      = ret_q;
        issue      = 1'b0;
        ret        = 1'b0;
        pair_done  = 1'b0;
        l_rd_en_o  = 1'b0;
        r_rd_en_o  = 1'b0;
        lo_wr_en_o = 1'b0;
        ro_wr_en_o = 1'b0;

        // Strobes are qualified by reset so nothing fires while it is held.
        case (iss_q)
            ISS_L: if (reset_ni && enable_i && !l_empty_i && !dp_full_i && credit_ok) begin
                l_rd_en_o = 1'b1;
                issue     = 1'b1;
                iss_d     = ISS_R;
            end
            ISS_R: if (reset_ni && !r_empty_i && !dp_full_i && credit_ok) begin
                r_rd_en_o = 1'b1;
                issue     = 1'b1;
                iss_d     = ISS_L;
            end
        endcase

        case (ret_q)
            RET_L: if (reset_ni && !dp_empty_i && !lo_full_i) begin
                lo_wr_en_o = 1'b1;
                ret        = 1'b1;
                ret_d      = RET_R;
            end
            RET_R: if (reset_ni && !dp_empty_i && !ro_full_i) begin
                ro_wr_en_o = 1'b1;
                ret        = 1'b1;
                pair_done  = 1'b1;
                ret_d      = RET_L;
            end
        endcase

        case ({issue, ret})
            2'b10:   in_flight_d = in_flight_q + CW'(1);
            2'b01:   in_flight_d = in_flight_q - CW'(1);
            default: in_flight_d = in_flight_q;
        endcase

        pair_cnt_d = pair_done ? pair_cnt_q + 32'd1 : pair_cnt_q;
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            iss_q       <= ISS_L;
            ret_q       <= RET_L;
            in_flight_q <= '0;
            pair_cnt_q  <= '0;
        end else begin
            iss_q       <= iss_d;
            ret_q       <= ret_d;
            in_flight_q <= in_flight_d;
            pair_cnt_q  <= pair_cnt_d;
        end
    end

    assign dp_wr_en_o  = issue;
    assign dp_rd_en_o  = ret;
    assign dp_din_o    = (iss_q == ISS_L) ? l_dout_i : r_dout_i;
    assign lo_din_o    = dp_dout_i;
    assign ro_din_o    = dp_dout_i;
    assign in_flight_o = in_flight_q;
    assign pair_cnt_o  = pair_cnt_q;
    assign busy_o      = (iss_q == ISS_R) || (in_flight_q != '0);

endmodule

// File: tb/tb_deemph_stereo_sched.sv
// Directed bench for deemph_stereo_sched (MAX_INFLIGHT=4): a vector table for
// single-cycle behaviour, then hand sequences with small FIFO models for ordering and reset.
module tb_deemph_stereo_sched;

    localparam int DW = 32;
    localparam int MI = 4;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst_n, en, l_empty, r_empty, dp_full, dp_empty, lo_full, ro_full;
    logic [DW-1:0] l_dout, r_dout, dp_dout;
    logic          l_rd_en, r_rd_en, dp_wr_en, dp_rd_en, lo_wr_en, ro_wr_en, busy;
    logic [DW-1:0] dp_din, lo_din, ro_din;
    logic [CW-1:0] in_flight;
    logic [31:0]   pair_cnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    deemph_stereo_sched #(.DATA_WIDTH(DW), .MAX_INFLIGHT(MI)) dut (
        .clock_i(clk), .reset_ni(rst_n), .enable_i(en),
        .l_empty_i(l_empty), .l_rd_en_o(l_rd_en), .l_dout_i(l_dout),
        .r_empty_i(r_empty), .r_rd_en_o(r_rd_en), .r_dout_i(r_dout),
        .dp_full_i(dp_full), .dp_wr_en_o(dp_wr_en), .dp_din_o(dp_din),
        .dp_empty_i(dp_empty), .dp_rd_en_o(dp_rd_en), .dp_dout_i(dp_dout),
        .lo_full_i(lo_full), .lo_wr_en_o(lo_wr_en), .lo_din_o(lo_din),
        .ro_full_i(ro_full), .ro_wr_en_o(ro_wr_en), .ro_din_o(ro_din),
        .in_flight_o(in_flight), .pair_cnt_o(pair_cnt), .busy_o(busy)
    );

    typedef struct packed {
        logic rst, en, le; logic [31:0] ld;
        logic re; logic [31:0] rd;
        logic dpf, dpe; logic [31:0] dpd;
        logic lof, rof;
    } vin_t;

    typedef struct packed {
        logic l_rd, r_rd, dp_wr; logic [31:0] din;
        logic dp_rd, lo_wr, ro_wr;
        logic [2:0] inf; logic [31:0] pc; logic busy;
    } vout_t;

    typedef struct packed { vin_t i; vout_t o; } vec_t;

    vec_t vecs[18];

    function automatic vec_t mk(
        input logic rst, en, le, input logic [31:0] ld, input logic re, input logic [31:0] rd,
        input logic dpf, dpe, input logic [31:0] dpd, input logic lof, rof,
        input logic lr, rr, dw, input logic [31:0] din, input logic drd, low, row,
        input logic [2:0] inf, input logic [31:0] pc, input logic bsy);
        vec_t v;
        v.i = '{rst: rst, en: en, le: le, ld: ld, re: re, rd: rd, dpf: dpf, dpe: dpe,
                dpd: dpd, lof: lof, rof: rof};
        v.o = '{l_rd: lr, r_rd: rr, dp_wr: dw, din: din, dp_rd: drd, lo_wr: low,
                ro_wr: row, inf: inf, pc: pc, busy: bsy};
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        rst_n = 1'b1; en = 1'b1; l_empty = 1'b1; r_empty = 1'b1; dp_full = 1'b0;
        dp_empty = 1'b1; lo_full = 1'b0; ro_full = 1'b0;
        l_dout = '0; r_dout = '0; dp_dout = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Bench-side FIFO contents for the loopback sequence
    logic [31:0] l_q[$], r_q[$], dp_q[$], dp_log[$], lo_log[$], ro_log[$];

    initial begin
        vout_t act;
        logic  s_lrd, s_rrd, s_dwr, s_drd;
        logic [31:0] s_din;

        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);

        //           rst en le ld    re rd    dpf dpe dpd   lof rof | lr rr dw din   drd lo ro inf pc bsy
        vecs[0]  = mk(0, 1, 0, 'h11, 0, 'h22, 0, 0, 'hA0, 0, 0,   0, 0, 0, 'h11, 0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(1, 1, 0, 'h11, 1, 'h22, 0, 1, 'hA0, 0, 0,   1, 0, 1, 'h11, 0, 0, 0, 0, 0, 0);
        vecs[2]  = mk(1, 1, 0, 'h11, 1, 'h22, 0, 1, 'hA0, 0, 0,   0, 0, 0, 'h22, 0, 0, 0, 1, 0, 1);
        vecs[3]  = mk(1, 1, 0, 'h11, 0, 'h22, 1, 1, 'hA0, 0, 0,   0, 0, 0, 'h22, 0, 0, 0, 1, 0, 1);
        vecs[4]  = mk(1, 1, 0, 'h11, 0, 'h22, 0, 1, 'hA0, 0, 0,   0, 1, 1, 'h22, 0, 0, 0, 1, 0, 1);
        vecs[5]  = mk(1, 0, 0, 'h33, 0, 'h44, 0, 1, 'hA0, 0, 0,   0, 0, 0, 'h33, 0, 0, 0, 2, 0, 1);
        vecs[6]  = mk(1, 1, 0, 'h33, 0, 'h44, 0, 1, 'hA0, 0, 0,   1, 0, 1, 'h33, 0, 0, 0, 2, 0, 1);
        vecs[7]  = mk(1, 1, 0, 'h33, 0, 'h44, 0, 1, 'hA0, 0, 0,   0, 1, 1, 'h44, 0, 0, 0, 3, 0, 1);
        vecs[8]  = mk(1, 1, 0, 'h33, 0, 'h44, 0, 1, 'hA0, 0, 0,   0, 0, 0, 'h33, 0, 0, 0, 4, 0, 1);
        vecs[9]  = mk(1, 1, 0, 'h33, 0, 'h44, 0, 0, 'hA1, 0, 0,   0, 0, 0, 'h33, 1, 1, 0, 4, 0, 1);
        vecs[10] = mk(1, 1, 0, 'h33, 0, 'h44, 0, 0, 'hB2, 0, 1,   1, 0, 1, 'h33, 0, 0, 0, 3, 0, 1);
        vecs[11] = mk(1, 1, 0, 'h33, 0, 'h55, 0, 0, 'hB2, 0, 0,   0, 0, 0, 'h55, 1, 0, 1, 4, 0, 1);
        vecs[12] = mk(1, 1, 0, 'h33, 0, 'h55, 0, 0, 'hC3, 0, 0,   0, 1, 1, 'h55, 1, 1, 0, 3, 1, 1);
        vecs[13] = mk(1, 1, 1, 'h33, 1, 'h55, 0, 0, 'hD4, 0, 0,   0, 0, 0, 'h33, 1, 0, 1, 3, 1, 1);
        vecs[14] = mk(1, 1, 1, 'h33, 1, 'h55, 0, 0, 'hE5, 1, 0,   0, 0, 0, 'h33, 0, 0, 0, 2, 2, 1);
        vecs[15] = mk(1, 1, 1, 'h33, 1, 'h55, 0, 0, 'hE5, 0, 0,   0, 0, 0, 'h33, 1, 1, 0, 2, 2, 1);
        vecs[16] = mk(1, 1, 1, 'h33, 1, 'h55, 0, 0, 'hF6, 0, 0,   0, 0, 0, 'h33, 1, 0, 1, 1, 2, 1);
        vecs[17] = mk(1, 1, 1, 'h33, 1, 'h55, 0, 1, 'hF6, 0, 0,   0, 0, 0, 'h33, 0, 0, 0, 0, 3, 0);

        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            rst_n = vecs[k].i.rst; en = vecs[k].i.en;
            l_empty = vecs[k].i.le; l_dout = vecs[k].i.ld;
            r_empty = vecs[k].i.re; r_dout = vecs[k].i.rd;
            dp_full = vecs[k].i.dpf; dp_empty = vecs[k].i.dpe; dp_dout = vecs[k].i.dpd;
            lo_full = vecs[k].i.lof; ro_full = vecs[k].i.rof;
            #1;
            act = '{l_rd: l_rd_en, r_rd: r_rd_en, dp_wr: dp_wr_en, din: dp_din, dp_rd: dp_rd_en,
                    lo_wr: lo_wr_en, ro_wr: ro_wr_en, inf: in_flight, pc: pair_cnt, busy: busy};
            n_vec++;
            if (act !== vecs[k].o) begin
                n_err++;
                $display("FAIL vec%0d: got %h, expected %h", k, act, vecs[k].o);
            end
        end

        // Loopback: datapath output FIFO is fed straight from its input
        do_reset();
        l_q = '{1, 2, 3}; r_q = '{10, 20, 30};
        for (int c = 0; c < 60 && ro_log.size() < 3; c++) begin
            @(negedge clk);
            l_empty  = (l_q.size() == 0);  l_dout  = l_empty  ? '0 : l_q[0];
            r_empty  = (r_q.size() == 0);  r_dout  = r_empty  ? '0 : r_q[0];
            dp_empty = (dp_q.size() == 0); dp_dout = dp_empty ? '0 : dp_q[0];
            #1;
            s_lrd = l_rd_en; s_rrd = r_rd_en; s_dwr = dp_wr_en; s_drd = dp_rd_en; s_din = dp_din;
            if (dp_wr_en) dp_log.push_back(dp_din);
            if (lo_wr_en) lo_log.push_back(lo_din);
            if (ro_wr_en) ro_log.push_back(ro_din);
            @(posedge clk);
            if (s_lrd) void'(l_q.pop_front());
            if (s_rrd) void'(r_q.pop_front());
            if (s_drd) void'(dp_q.pop_front());
            if (s_dwr) dp_q.push_back(s_din);
        end
        @(negedge clk);
        dp_empty = 1'b1; l_empty = 1'b1; r_empty = 1'b1;
        #1;
        check("t1_dp_cnt", dp_log.size(), 6);
        check("t1_dp0", dp_log.size() > 0 ? dp_log[0] : 'x, 1);
        check("t1_dp1", dp_log.size() > 1 ? dp_log[1] : 'x, 10);
        check("t1_dp2", dp_log.size() > 2 ? dp_log[2] : 'x, 2);
        check("t1_dp3", dp_log.size() > 3 ? dp_log[3] : 'x, 20);
        check("t1_dp4", dp_log.size() > 4 ? dp_log[4] : 'x, 3);
        check("t1_dp5", dp_log.size() > 5 ? dp_log[5] : 'x, 30);
        check("t1_lo", lo_log.size() == 3 ? {lo_log[0][7:0], lo_log[1][7:0], lo_log[2][7:0]} : 'x, 32'h010203);
        check("t1_ro", ro_log.size() == 3 ? {ro_log[0][7:0], ro_log[1][7:0], ro_log[2][7:0]} : 'x, 32'h0A141E);
        check("t1_pair_cnt", pair_cnt, 3);
        check("t1_in_flight", 32'(in_flight), 0);

        // Enable dropped right after an L issue: R still follows, then no L
        en = 1'b1; l_empty = 1'b0; l_dout = 'h71; r_empty = 1'b0; r_dout = 'h72;
        #1 check("t5_l_issue", {l_rd_en, dp_wr_en}, 2'b11);
        @(negedge clk);
        en = 1'b0;
        #1 check("t5_r_issue", {r_rd_en, dp_wr_en, dp_din}, {2'b11, 32'h72});
        @(negedge clk);
        #1 check("t5_no_l", {l_rd_en, dp_wr_en, busy}, 3'b001);
        @(negedge clk);
        dp_empty = 1'b0; dp_dout = 'h81;
        @(negedge clk);
        dp_dout = 'h82;
        @(negedge clk);
        dp_empty = 1'b1;
        #1 check("t5_busy_drop", {busy, 29'd0, in_flight}, 32'd0);
        check("t5_pair_cnt", pair_cnt, 4);

        // Empty R stalls the issue side even with L data waiting
        en = 1'b1; l_empty = 1'b0; l_dout = 5; r_empty = 1'b1;
        #1 check("t2_l5", {l_rd_en, dp_din}, {1'b1, 32'd5});
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            l_dout = 6;
            #1 check("t2_stall", {l_rd_en, r_rd_en, dp_wr_en, busy}, 4'b0001);
        end
        @(negedge clk);
        r_empty = 1'b0; r_dout = 9;
        #1 check("t2_r9", {r_rd_en, dp_wr_en, dp_din}, {2'b11, 32'd9});
        @(negedge clk);
        r_empty = 1'b1;
        #1 check("t2_l6", {l_rd_en, dp_din}, {1'b1, 32'd6});

        // Reset with three samples in flight while waiting on R
        @(negedge clk);
        check("t6_pre_inflight", 32'(in_flight), 3);
        r_empty = 1'b0; dp_empty = 1'b0; l_empty = 1'b0;
        rst_n = 1'b0;
        #1 check("t6_strobes", {l_rd_en, r_rd_en, dp_wr_en, dp_rd_en, lo_wr_en, ro_wr_en}, 6'b0);
        check("t6_inflight_rst", {pair_cnt[28:0], in_flight}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1; dp_empty = 1'b1; l_dout = 'hA5; r_dout = 'h5A;
        #1 check("t6_first_l", {l_rd_en, r_rd_en, dp_din}, {2'b10, 32'hA5});
        check("t6_pair_cnt", pair_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
